// File: rtl/mycpu_pkg.sv
// Shared definitions for the fetch stage.
// FS_TO_DS_BUS_WD : width of the fetch-to-decode bus {adel, pc, inst}.
// FS_*            : bit positions of the fields inside that bus.
// INST_SIZE_*     : instruction-SRAM transfer size encodings.
package mycpu_pkg;
  localparam int FS_TO_DS_BUS_WD = 65;
  localparam int FS_INST_LSB     = 0;
  localparam int FS_INST_MSB     = 31;
  localparam int FS_PC_LSB       = 32;
  localparam int FS_PC_MSB       = 63;
  localparam int FS_ADEL_BIT     = 64;

  localparam logic [1:0] INST_SIZE_BYTE = 2'd0;
  localparam logic [1:0] INST_SIZE_HALF = 2'd1;
  localparam logic [1:0] INST_SIZE_WORD = 2'd2;
endpackage

// File: rtl/if_ibuf.sv
// Synchronous FIFO that buffers fetched instructions ahead of decode.
// clk, reset : clock, synchronous active-high reset
// clear_i    : drop all entries (redirect), wins over push
// push_i     : write data_i; accepted when not full or when popping too
// pop_i      : remove head entry (ignored when empty)
// data_o     : head entry
// count_o    : occupancy; full_o / empty_o : status flags
module if_ibuf #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH_CNT);
  assign count_o = cnt_q;
  assign data_o  = mem[rd_q];

  assign pop_ok  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop_ok)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear_i) mem[wr_q] <= data_i;
  end
endmodule

// File: rtl/if_stage_buf.sv
// Instruction-fetch stage with split-handshake SRAM interface, in-order
// outstanding requests, an instruction buffer before decode, branch/exception
// redirect with squashing of stale responses, and misaligned-PC detection.
// flush/flush_pc, br_valid/br_target : redirect sources (flush wins)
// ds_allowin, fs_to_ds_valid, fs_to_ds_bus : decode handshake, bus {adel, pc, inst}
// inst_req/inst_addr/inst_addr_ok : request phase; inst_data_ok/inst_rdata : response
// inst_wr, inst_size, inst_wdata : constant read-word controls
module if_stage_buf
  import mycpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'hbfc00000,
  parameter int          IBUF_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [31:0]                flush_pc,
  input  logic                       br_valid,
  input  logic [31:0]                br_target,
  input  logic                       ds_allowin,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_req,
  output logic                       inst_wr,
  output logic [1:0]                 inst_size,
  output logic [31:0]                inst_addr,
  output logic [31:0]                inst_wdata,
  input  logic                       inst_addr_ok,
  input  logic                       inst_data_ok,
  input  logic [31:0]                inst_rdata
);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int FCW = $clog2(IBUF_DEPTH + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [QW-1:0] Q_LAST  = QW'(MAX_OUTSTANDING - 1);
  localparam logic [31:0]   DEPTH32 = 32'(IBUF_DEPTH);

  logic [31:0]   pc_req_q, pc_req_d, redirect_pc_q, redirect_pc_d;
  logic [CW-1:0] inflight_q, inflight_d, discard_q, discard_d;
  logic          req_hold_q, req_hold_d, redirect_pend_q, redirect_pend_d;
  logic          adel_sent_q, adel_sent_d;
  logic [QW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [31:0]   pcq [MAX_OUTSTANDING];

  logic                       redirect, misaligned, credit_ok, accept, ret;
  logic                       ret_push, adel_push, push, pop;
  logic [31:0]                redirect_tgt, occupancy;
  logic [FS_TO_DS_BUS_WD-1:0] push_data;
  logic [FCW-1:0]             fifo_count;
  logic                       fifo_full, fifo_empty;

  function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
    return (p == Q_LAST) ? '0 : p + QW'(1);
  endfunction

  assign redirect     = flush || br_valid;
  assign redirect_tgt = flush ? flush_pc : br_target;
  assign misaligned   = (pc_req_q[1:0] != 2'b00);

  // Buffered entries plus every response still owed a slot; discarded
  // responses never reach the FIFO so they do not consume credit.
  assign occupancy = 32'(fifo_count) + 32'(inflight_q) - 32'(discard_q);
  assign credit_ok = (occupancy < DEPTH32);

  // A request left un-acknowledged must stay up until accepted.
  assign inst_req   = !reset && (req_hold_q ||
                      (!misaligned && (inflight_q < MAX_CNT) && credit_ok));
  assign inst_addr  = pc_req_q;
  assign inst_wr    = 1'b0;
  assign inst_size  = INST_SIZE_WORD;
  assign inst_wdata = 32'h0;

  assign accept    = inst_req && inst_addr_ok;
  assign ret       = inst_data_ok;
  // Responses are squashed while stale requests drain, and in a redirect cycle.
  assign ret_push  = ret && !redirect && (discard_q == '0);
  assign adel_push = misaligned && !adel_sent_q && !redirect && credit_ok &&
                     !ret_push && (!fifo_full || pop);
  assign push      = ret_push || adel_push;
  assign push_data = ret_push ? {1'b0, pcq[pcq_rd_q], inst_rdata}
                              : {1'b1, pc_req_q, 32'h0};

  assign fs_to_ds_valid = !fifo_empty && !redirect;
  assign pop            = fs_to_ds_valid && ds_allowin;

  assign inflight_d = inflight_q + CW'(accept) - CW'(ret);
  assign pcq_wr_d   = accept ? ptr_inc(pcq_wr_q) : pcq_wr_q;
  assign pcq_rd_d   = ret    ? ptr_inc(pcq_rd_q) : pcq_rd_q;

  always_comb begin
    pc_req_d        = pc_req_q;
    redirect_pc_d   = redirect_pc_q;
    redirect_pend_d = redirect_pend_q;
    discard_d       = discard_q;
    adel_sent_d     = adel_sent_q;
    req_hold_d      = inst_req && !inst_addr_ok;

    if (ret && (discard_q != '0)) discard_d = discard_q - CW'(1);
    if (accept) begin
      pc_req_d = pc_req_q + 32'd4;
      if (redirect_pend_q) begin
        // The held request belonged to the old path: squash its response.
        pc_req_d        = redirect_pc_q;
        redirect_pend_d = 1'b0;
        discard_d       = discard_d + CW'(1);
      end
    end
    if (adel_push) adel_sent_d = 1'b1;

    if (redirect) begin
      // Every request still in flight after this edge is on the old path.
      discard_d   = inflight_d;
      adel_sent_d = 1'b0;
      if (inst_req && !inst_addr_ok) begin
        redirect_pend_d = 1'b1;
        redirect_pc_d   = redirect_tgt;
      end else begin
        pc_req_d        = redirect_tgt;
        redirect_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_req_q        <= RESET_PC;
      redirect_pc_q   <= RESET_PC;
      inflight_q      <= '0;
      discard_q       <= '0;
      req_hold_q      <= 1'b0;
      redirect_pend_q <= 1'b0;
      adel_sent_q     <= 1'b0;
      pcq_wr_q        <= '0;
      pcq_rd_q        <= '0;
    end else begin
      pc_req_q        <= pc_req_d;
      redirect_pc_q   <= redirect_pc_d;
      inflight_q      <= inflight_d;
      discard_q       <= discard_d;
      req_hold_q      <= req_hold_d;
      redirect_pend_q <= redirect_pend_d;
      adel_sent_q     <= adel_sent_d;
      pcq_wr_q        <= pcq_wr_d;
      pcq_rd_q        <= pcq_rd_d;
    end
  end

  // PC of each accepted request, consumed in order as responses return.
  always_ff @(posedge clk) begin
    if (accept) pcq[pcq_wr_q] <= pc_req_q;
  end

  if_ibuf #(
    .WIDTH(FS_TO_DS_BUS_WD),
    .DEPTH(IBUF_DEPTH)
  ) u_ibuf (
    .clk    (clk),
    .reset  (reset),
    .clear_i(redirect),
    .push_i (push),
    .pop_i  (pop),
    .data_i (push_data),
    .data_o (fs_to_ds_bus),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );
endmodule

// File: tb/tb_if_stage_buf.sv
module tb_if_stage_buf;
  logic        clk = 1'b0;
  logic        reset, flush, br_valid, ds_allowin;
  logic [31:0] flush_pc, br_target;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'h0;

  always #5 clk = ~clk;

  if_stage_buf dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
    .br_valid(br_valid), .br_target(br_target), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata)
  );

  int n_chk = 0, n_fail = 0;
  int ok_delay = 0, lat = 1;
  int cyc = 0, wait_cnt = 0, req_cycles = 0, stab_viol = 0;
  logic        last_unacked = 1'b0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] pq_addr[$];
  int          pq_due[$];
  logic [31:0] acc_log[$];
  logic [64:0] dec_log[$];
  int am, dm, rm;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ 32'h5a5a_a5a5;
  endfunction

  function automatic logic [64:0] ent(input logic adel, input logic [31:0] pc);
    return adel ? {1'b1, pc, 32'h0} : {1'b0, pc, rd(pc)};
  endfunction

  function automatic logic [64:0] dec_at(input int i);
    if (i < dec_log.size()) return dec_log[i];
    return '1;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return 32'hffff_ffff;
  endfunction

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Memory model and decode monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      pq_addr.delete();
      pq_due.delete();
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      wait_cnt     = 0;
      last_unacked = 1'b0;
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = 32'h0;
      if (pq_addr.size() > 0 && pq_due[0] <= cyc) begin
        inst_data_ok = 1'b1;
        inst_rdata   = rd(pq_addr[0]);
        void'(pq_addr.pop_front());
        void'(pq_due.pop_front());
      end
      if (inst_req) begin
        req_cycles++;
        if (last_unacked && inst_addr != last_addr) stab_viol++;
        if (wait_cnt >= ok_delay) begin
          inst_addr_ok = 1'b1;
          acc_log.push_back(inst_addr);
          pq_addr.push_back(inst_addr);
          pq_due.push_back(cyc + lat);
          wait_cnt     = 0;
          last_unacked = 1'b0;
        end else begin
          inst_addr_ok = 1'b0;
          wait_cnt++;
          last_unacked = 1'b1;
          last_addr    = inst_addr;
        end
      end else begin
        inst_addr_ok = 1'b0;
        if (last_unacked) stab_viol++;
        wait_cnt     = 0;
        last_unacked = 1'b0;
      end
      if (fs_to_ds_valid && ds_allowin) dec_log.push_back(fs_to_ds_bus);
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; br_valid = 1'b0; ds_allowin = 1'b1;
    flush_pc = 32'h0; br_target = 32'h0;

    // Reset state, then straight-line fetch with 0-wait memory.
    tick(3);
    chk("rst_valid", 65'(fs_to_ds_valid), 65'd0);
    chk("rst_req", 65'(inst_req), 65'd0);
    chk("const_ctl", {inst_wr, inst_size, inst_wdata}, {1'b0, 2'd2, 32'h0});
    am = acc_log.size(); dm = dec_log.size();
    reset = 1'b0;
    tick(12);
    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", 65'(acc_at(am + i)), 65'(32'hbfc00000 + 32'(4 * i)));
      chk("seq_dec", dec_at(dm + i), ent(1'b0, 32'hbfc00000 + 32'(4 * i)));
    end

    // Decode stalled: buffer fills to depth, requests stop, nothing lost.
    ds_allowin = 1'b0;
    do_reset();
    am = acc_log.size(); dm = dec_log.size();
    tick(20);
    chk("stall_req", 65'(inst_req), 65'd0);
    chk("stall_acc", 65'(acc_log.size() - am), 65'd4);
    chk("stall_dec", 65'(dec_log.size() - dm), 65'd0);
    ds_allowin = 1'b1;
    tick(30);
    for (int i = 0; i < 10; i++)
      chk("stall_order", dec_at(dm + i), ent(1'b0, 32'hbfc00000 + 32'(4 * i)));

    // Branch while a request waits for addr_ok.
    ok_delay = 3;
    do_reset();
    am = acc_log.size(); dm = dec_log.size();
    tick(1);
    br_valid = 1'b1; br_target = 32'h80001000;
    tick(1);
    br_valid = 1'b0;
    tick(25);
    chk("hold_addr0", 65'(acc_at(am)), 65'(32'hbfc00000));
    chk("hold_addr1", 65'(acc_at(am + 1)), 65'(32'h80001000));
    chk("hold_dec0", dec_at(dm), ent(1'b0, 32'h80001000));
    chk("hold_dec1", dec_at(dm + 1), ent(1'b0, 32'h80001004));
    ok_delay = 0;

    // Flush with two long-latency requests outstanding.
    lat = 5;
    do_reset();
    am = acc_log.size();
    tick(2);
    flush = 1'b1; flush_pc = 32'hbfc00380;
    dm = dec_log.size();
    tick(1);
    flush = 1'b0;
    tick(30);
    chk("flush_acc2", 65'(acc_at(am + 2)), 65'(32'hbfc00380));
    chk("flush_dec0", dec_at(dm), ent(1'b0, 32'hbfc00380));
    chk("flush_dec1", dec_at(dm + 1), ent(1'b0, 32'hbfc00384));
    lat = 1;

    // Flush and branch together with a full buffer: flush wins, valid masked.
    ds_allowin = 1'b0;
    do_reset();
    tick(12);
    dm = dec_log.size();
    flush = 1'b1; flush_pc = 32'hbfc00380;
    br_valid = 1'b1; br_target = 32'h80001000;
    ds_allowin = 1'b1;
    #3;
    chk("redir_valid", 65'(fs_to_ds_valid), 65'd0);
    tick(1);
    flush = 1'b0; br_valid = 1'b0;
    tick(15);
    chk("both_dec0", dec_at(dm), ent(1'b0, 32'hbfc00380));
    chk("both_dec1", dec_at(dm + 1), ent(1'b0, 32'hbfc00384));

    // Misaligned target: single adel entry, no requests, idle.
    br_valid = 1'b1; br_target = 32'h80000002;
    dm = dec_log.size();
    tick(1);
    br_valid = 1'b0;
    rm = req_cycles;
    tick(15);
    chk("adel_noreq", 65'(req_cycles - rm), 65'd0);
    chk("adel_cnt", 65'(dec_log.size() - dm), 65'd1);
    chk("adel_ent", dec_at(dm), ent(1'b1, 32'h80000002));
    chk("adel_idle", 65'(fs_to_ds_valid), 65'd0);

    // Redirect out of the stall to the top of the address space: pc wraps.
    br_valid = 1'b1; br_target = 32'hfffffffc;
    dm = dec_log.size();
    tick(1);
    br_valid = 1'b0;
    tick(15);
    chk("wrap_dec0", dec_at(dm), ent(1'b0, 32'hfffffffc));
    chk("wrap_dec1", dec_at(dm + 1), ent(1'b0, 32'h00000000));
    chk("req_stable", 65'(stab_viol), 65'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/if_stage_buf.md
Name: if_stage_buf

Overview:
- Next-generation instruction-fetch stage with a split-handshake instruction-SRAM interface (req/addr_ok, then data_ok), so memory latency may vary.
- Allows up to MAX_OUTSTANDING in-order fetches in flight and buffers returned instructions in an IBUF_DEPTH FIFO before decode.
- Supports branch redirect and exception flush; responses to squashed requests are discarded.
- Flags misaligned PCs as an address-error exception.
- Sits between the branch/exception redirect sources and the decode stage.

Parameters:
- RESET_PC, 32'hbfc00000, first fetch address after reset.
- IBUF_DEPTH, 4, instruction FIFO entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum accepted-but-unreturned requests (1..IBUF_DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  exception/eret redirect, single-cycle pulse.
- flush_pc  in  32  redirect target, valid with flush.
- br_valid  in  1  branch redirect, single-cycle pulse. Asserted only after the delay slot has left IF.
- br_target  in  32  branch target.
- ds_allowin  in  1  decode can accept.
- fs_to_ds_valid  out  1  head of FIFO valid.
- fs_to_ds_bus  out  65  {adel, pc[31:0], inst[31:0]}.
- inst_req  out  1  fetch request.
- inst_wr  out  1  tied 0.
- inst_size  out  2  tied 2'd2.
- inst_addr  out  32  fetch address.
- inst_wdata  out  32  tied 0.
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  response valid this cycle, in request order.
- inst_rdata  in  32  response data.

Behaviour:
- Reset (synchronous): pc_req=RESET_PC, inflight=0, discard_cnt=0, FIFO empty, req_hold=0, redirect_pend=0. Outputs: fs_to_ds_valid=0, inst_req=0.
- Request issue: inst_req=1 when all of the following hold: !reset, pc_req[1:0]==0, inflight<MAX_OUTSTANDING, and (fifo_count + inflight - discard_cnt) < IBUF_DEPTH.
- Credit rule: the FIFO can never overflow.
- Accept: inst_req && inst_addr_ok. On accept, inflight+1 and pc_req += 4, unless a redirect applies (see below).
- Request stability: once inst_req=1 without inst_addr_ok, inst_req and inst_addr stay constant until accepted.
  - A redirect arriving during that window is latched in redirect_pend/redirect_pc.
  - The held request is tagged for discard when accepted.
  - pc_req <= redirect_pc in the accept cycle.
- Return: each inst_data_ok decrements inflight.
  - If discard_cnt>0: decrement discard_cnt and drop the data.
  - Otherwise push {0, pc, rdata}; the pc comes from a MAX_OUTSTANDING-deep in-flight PC queue.
- Misaligned pc_req (pc_req[1:0]!=0): issue no request. When FIFO space exists, push {1, pc_req, 32'h0} once, then stall until a redirect.
- Redirect (flush, or br_valid when !flush; flush wins):
  - FIFO cleared in the same edge.
  - discard_cnt <= inflight_next, where inflight_next includes a request accepted this cycle and excludes a return this cycle.
  - A return arriving in the redirect cycle is dropped.
  - pc_req <= target. If a held request is pending, the target goes to redirect_pend instead and pc_req follows on acceptance.
  - fs_to_ds_valid forced 0 in the redirect cycle.
  - Fetch from the target may start the next cycle.
- Decode handshake: pop when fs_to_ds_valid && ds_allowin. Push and pop in the same cycle are allowed, including when the FIFO is full (pop frees the slot).
- Latency: with addr_ok/data_ok asserted in consecutive cycles and an empty FIFO, an instruction is visible at decode 1 cycle after data_ok (registered FIFO).
- Back-to-back redirects: each redirect recomputes discard_cnt = inflight_next. Earlier discards are subsumed because every in-flight request is older.
- Widths: pc arithmetic modulo 2^32 (wrap from 32'hfffffffc to 0). Counters sized $clog2(MAX+1).

Decomposition:
- Shared package mycpu_pkg:
  - FS_TO_DS_BUS_WD=65.
  - Field offsets of fs_to_ds_bus.
  - Instruction-SRAM size encoding constants.
- One sub-module: if_ibuf, a parametrised synchronous FIFO with flush (clear), push, pop, count and full/empty outputs.
- Request/discard control stays in if_stage_buf.

Test Plan:
- Reset release, memory with 0-wait addr_ok and 1-cycle data_ok, ds_allowin=1 → first inst_addr=32'hbfc00000, then 32'hbfc00004, 32'hbfc00008; decode sees pcs in order with adel=0.
- ds_allowin=0 for 20 cycles → no more than IBUF_DEPTH=4 instructions buffered, inst_req drops, none lost; release → pcs consecutive, no duplicates.
- addr_ok delayed 3 cycles with br_valid (br_target=32'h80001000) pulsed in the wait → inst_addr held at old value until accepted; that response discarded; next accepted addr 32'h80001000.
- 2 requests outstanding (data_ok latency 5) and flush with flush_pc=32'hbfc00380 → both stale responses dropped; first decoded pc = 32'hbfc00380.
- flush and br_valid in the same cycle → flush_pc used.
- br_target=32'h80000002 → no inst_req; one entry {adel=1, pc=32'h80000002, inst=0} delivered; then idle until a redirect.
